// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared types and constants for the 2:1 mux arbiter.
//   state_t : arbiter FSM encoding (IDLE, GRANT0, GRANT1)
//   CNT_W   : width of the per-grant beat counter
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mux2_wide.sv
// mux2_wide: combinational WIDTH-bit 2:1 multiplexer.
//   D0, D1 : data inputs
//   S      : select (0 -> D0, 1 -> D1)
//   Y      : selected data
module mux2_wide #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);

  assign Y = S ? D1 : D0;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin, burst-oriented arbiter sharing one registered
// WIDTH-bit output channel between two requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   REQ0/D0/LAST0/ACK0  : requester 0 handshake, data, end-of-burst, accept
//   REQ1/D1/LAST1/ACK1  : requester 1 handshake, data, end-of-burst, accept
//   S                   : registered mux select (0 = D0, 1 = D1)
//   Y, Y_VALID, Y_READY : registered output beat with valid/ready handshake
//   BUSY                : a grant is active
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             LAST0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  input  logic             LAST1,
  output logic             ACK1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VALID,
  input  logic             Y_READY,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state_q;
  logic             prio_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_q;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  logic             can_accept;
  logic             beat;
  logic             own_req;
  logic             own_last;
  logic             oth_req;
  logic             rel;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] mux_y;

  // s_q already points at the granted requester while in GRANTx, so the
  // mux output is the beat to capture.
  mux2_wide #(.WIDTH(WIDTH)) u_mux (
    .D0 (D0),
    .D1 (D1),
    .S  (s_q),
    .Y  (mux_y)
  );

  assign can_accept = !y_valid_q || Y_READY;
  assign ACK0       = (state_q == GRANT0) && REQ0 && can_accept;
  assign ACK1       = (state_q == GRANT1) && REQ1 && can_accept;
  assign beat       = ACK0 || ACK1;

  assign own_req  = (state_q == GRANT1) ? REQ1  : REQ0;
  assign own_last = (state_q == GRANT1) ? LAST1 : LAST0;
  assign oth_req  = (state_q == GRANT1) ? REQ0  : REQ1;
  assign cnt_inc  = cnt_q + ONE;

  // Release on abandon, on a LAST beat, or on the MAX_BURST-th beat.
  assign rel = (state_q == GRANT0 || state_q == GRANT1) &&
               (!own_req || (beat && (own_last || cnt_inc == MAX_B)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      // Output register: load on a beat, drain when the consumer takes it,
      // otherwise hold (backpressure).
      if (beat) begin
        y_q       <= mux_y;
        y_valid_q <= 1'b1;
      end else if (Y_READY) begin
        y_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (REQ0 && (!REQ1 || !prio_q)) begin
            state_q <= GRANT0;
            s_q     <= 1'b0;
          end else if (REQ1) begin
            state_q <= GRANT1;
            s_q     <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (rel) begin
            prio_q <= (state_q == GRANT0);
            cnt_q  <= '0;
            // Direct handover to a pending partner; otherwise go idle, so a
            // repeat grant to the same requester costs one bubble.
            if (oth_req) begin
              state_q <= (state_q == GRANT0) ? GRANT1 : GRANT0;
              s_q     <= (state_q == GRANT0);
            end else begin
              state_q <= IDLE;
            end
          end else if (beat) begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S       = s_q;
  assign Y       = y_q;
  assign Y_VALID = y_valid_q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Sequential controller for the team's 2:1 mux datapath. It shares one WIDTH-bit output channel between two requesters and drives the mux select `S`. Grants are round-robin and burst-oriented, with a valid/ready handshake and a registered output stage. It sits between two producer blocks and a single downstream consumer.

## Interface
Parameters:
- `WIDTH`, 8: data width of `D0`, `D1` and `Y`.
- `MAX_BURST`, 4: maximum beats per grant. Legal range is 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset. Assertion is asynchronous.
- `REQ0`  in  1  requester 0 has a beat on `D0`.
- `D0`  in  WIDTH  requester 0 data.
- `LAST0`  in  1  current `D0` beat ends requester 0's burst.
- `ACK0`  out  1  requester 0 beat accepted this cycle (combinational).
- `REQ1`, `D1`, `LAST1`, `ACK1`: same as above, for requester 1.
- `S`  out  1  mux select. 0 selects `D0`, 1 selects `D1`. Registered.
- `Y`  out  WIDTH  output data. Registered.
- `Y_VALID`  out  1  `Y` holds a beat.
- `Y_READY`  in  1  downstream accepts `Y` this cycle.
- `BUSY`  out  1  a grant is active (state ≠ IDLE).

## Operation
- States:
  - IDLE: no grant.
  - GRANT0: requester 0 owns the channel.
  - GRANT1: requester 1 owns the channel.
- `PRIO` register (reset 0) names the favoured requester.
- IDLE transitions:
  - Only `REQ0` high → GRANT0. Only `REQ1` high → GRANT1.
  - Both high → GRANTx where x = `PRIO`.
  - Neither high → stay in IDLE.
- `can_accept` = !`Y_VALID` || `Y_READY`.
- In GRANTx, a beat transfers when `REQx` && `can_accept`:
  - `ACKx` = 1.
  - `Y` ← `Dx` (through the mux, `S` = x).
  - `Y_VALID` ← 1.
  - Beat counter increments.
- If `Y_VALID` && `Y_READY` && no new beat, then `Y_VALID` ← 0.
- A grant is released on whichever comes first:
  - the accepted beat has `LASTx` = 1;
  - the accepted beat is number `MAX_BURST`;
  - `REQx` is low while GRANTx (abandon; no beat transfers).
- On release:
  - `PRIO` ← other requester.
  - Beat counter ← 0.
  - Next state is GRANT(other) if `REQ(other)` is high in the release cycle, else IDLE.
  - Back-to-back re-grant to the same requester happens only if the other requester is idle. This passes through IDLE, which costs one bubble cycle.
- `ACKx` is 0 whenever the state is not GRANTx. The two ACKs are never high together.
- `S` updates on the clock edge that enters GRANTx, and holds its value in IDLE.
- `Y` holds its value while `Y_VALID` && !`Y_READY` (backpressure). `Dx` is not re-sampled.
- Reset outputs:
  - `S`=0, `Y`=0, `Y_VALID`=0, `BUSY`=0, `ACK0`=`ACK1`=0.
  - State IDLE, `PRIO`=0, counter=0.
- Reset mid-burst discards the in-flight `Y` beat and the burst. The requester must resend.

## Timing
- Arbitration latency: `REQx` first seen high in IDLE at cycle T → GRANTx, `S`=x, `BUSY`=1 at T+1. Earliest `ACKx` is at T+1.
- Data latency: `ACKx` in cycle T → `Y`=`Dx`(T), `Y_VALID`=1 at T+1.
- Throughput is 1 beat/cycle while `Y_READY` is held high.
- Handover: release at cycle T with the other requester pending → GRANT(other) at T+1, first ACK at T+1. There is no bubble.
- Beat counter width is 8 bits. No wrap can occur, because release forces clear at `MAX_BURST`.
- `rst_n` deassertion must be synchronised externally to `clk`.

## Structure
- Package `mux2_arb_pkg` holds:
  - `state_t` enum: IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10;
  - `CNT_W`=8.
- Sub-module `mux2_wide`: combinational WIDTH-bit 2:1 mux (`D0`, `D1`, `S` → `Y`). The arbiter instantiates one copy, feeding the output register.
- Top module `mux2_arbiter` contains the FSM, `PRIO`, beat counter, and output register.

## Test plan
- Reset: hold `rst_n`=0 with `REQ0`=`REQ1`=1 → all outputs 0; release → GRANT0 next cycle, `S`=0.
- Contention: `REQ0`=`REQ1`=1, `LAST`=0, `MAX_BURST`=4, `Y_READY`=1 → Y sequence is 4 beats of `D0` then 4 beats of `D1`, alternating, with no bubble at handover.
- `LAST`: `REQ1` only, `D1`=8'hA5, `LAST1`=1 on the 2nd beat → 2 beats of 8'hA5, then IDLE, `BUSY`=0, `PRIO`=0.
- Backpressure: grant 0, `Y_READY`=0 for 3 cycles → `Y_VALID`=1, `Y` stable, `ACK0`=0. `Y_READY`=1 → one beat transfers per cycle.
- Abandon: GRANT1 and `REQ1` drops mid-burst while `REQ0`=1 → GRANT0 next cycle, `S`=0.
- Async reset mid-burst (`rst_n` low between edges) → `Y_VALID`=0 and `BUSY`=0 immediately, without waiting for a clock edge.
